// File: rtl/hdmi_i2c_init_seq.sv
// Power-up configuration sequencer for the ADV7511 HDMI transmitter behind a PCA9548 I2C switch.
// Walks a fixed register table through a byte-level I2C master, retrying NACKed transactions.
module hdmi_i2c_init_seq #(
   parameter int unsigned DELAY_CYC  = 2000000,
   parameter logic [6:0]  MUX_ADDR   = 7'h74,
   parameter logic [7:0]  MUX_CHAN   = 8'h20,
   parameter logic [6:0]  DEV_ADDR   = 7'h39,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned RETRY_GAP  = 1000,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic       sys0_clk,
   input  logic       sys0_rst,
   input  logic       start,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_data,
   output logic       cmd_start,
   output logic       cmd_stop,
   input  logic       rsp_valid,
   input  logic       rsp_nack,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] err_idx
);

   localparam int unsigned NUM_ENTRIES = 12;
   localparam int unsigned TXN_W       = 4;
   localparam int unsigned CNT_MAX     = (DELAY_CYC > RETRY_GAP) ? DELAY_CYC : RETRY_GAP;
   localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
   localparam int unsigned RTY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((DELAY_CYC > 0) ? DELAY_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_PWR, S_SEND, S_WAIT_RSP, S_GAP, S_DONE, S_ERROR
   } state_t;

   state_t             state_r, state_n;
   logic [TXN_W-1:0]   txn_r, txn_n;
   logic [1:0]         byte_r, byte_n;
   logic [RTY_W-1:0]   retry_r, retry_n;
   logic [CNT_W-1:0]   cnt_r, cnt_n, cnt_inc;
   logic [3:0]         err_idx_n;
   logic               auto_r;
   logic [1:0]         last_byte;

   logic               cmd_valid_n, cmd_start_n, cmd_stop_n;
   logic [7:0]         cmd_data_n;
   logic               busy_n, done_n, error_n;

   // ADV7511 register/value pairs, entries 1..12
   function automatic logic [15:0] tab_entry(input logic [TXN_W-1:0] idx);
      case (idx)
         4'd1:    tab_entry = 16'h41_10;
         4'd2:    tab_entry = 16'h98_03;
         4'd3:    tab_entry = 16'h9A_E0;
         4'd4:    tab_entry = 16'h9C_30;
         4'd5:    tab_entry = 16'h9D_61;
         4'd6:    tab_entry = 16'hA2_A4;
         4'd7:    tab_entry = 16'hA3_A4;
         4'd8:    tab_entry = 16'hE0_D0;
         4'd9:    tab_entry = 16'hF9_00;
         4'd10:   tab_entry = 16'h15_01;
         4'd11:   tab_entry = 16'h16_38;
         4'd12:   tab_entry = 16'hAF_06;
         default: tab_entry = 16'h00_00;
      endcase
   endfunction

   function automatic logic [7:0] byte_data(input logic [TXN_W-1:0] t, input logic [1:0] b);
      logic [15:0] ent;
      ent = tab_entry(t);
      if (b == 2'd0)
         byte_data = (t == '0) ? {MUX_ADDR, 1'b0} : {DEV_ADDR, 1'b0};
      else if (t == '0)
         byte_data = MUX_CHAN;
      else
         byte_data = (b == 2'd1) ? ent[15:8] : ent[7:0];
   endfunction

   function automatic logic [1:0] last_of(input logic [TXN_W-1:0] t);
      last_of = (t == '0) ? 2'd1 : 2'd2;
   endfunction

   // Next-state and next-output logic
   always_comb begin
      state_n   = state_r;
      txn_n     = txn_r;
      byte_n    = byte_r;
      retry_n   = retry_r;
      cnt_n     = cnt_r;
      err_idx_n = err_idx;
      cnt_inc   = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
      last_byte = last_of(txn_r);

      case (state_r)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start || (state_r == S_IDLE && auto_r)) begin
               state_n   = S_WAIT_PWR;
               cnt_n     = '0;
               err_idx_n = '0;
            end
         end
         S_WAIT_PWR: begin
            if (cnt_r >= DLY_LAST) begin
               state_n = S_SEND;
               txn_n   = '0;
               byte_n  = '0;
               retry_n = '0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         S_SEND: begin
            if (cmd_valid && cmd_ready) state_n = S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            if (rsp_valid) begin
               if (!rsp_nack) begin
                  if (byte_r != last_byte) begin
                     byte_n  = byte_r + 2'd1;
                     state_n = S_SEND;
                  end else if (txn_r == TXN_W'(NUM_ENTRIES)) begin
                     state_n = S_DONE;
                  end else begin
                     txn_n   = txn_r + TXN_W'(1);
                     byte_n  = '0;
                     retry_n = '0;
                     state_n = S_SEND;
                  end
               end else if (retry_r < RTY_W'(MAX_RETRY)) begin
                  retry_n = retry_r + RTY_W'(1);
                  byte_n  = '0;
                  cnt_n   = '0;
                  state_n = S_GAP;
               end else begin
                  err_idx_n = txn_r;
                  state_n   = S_ERROR;
               end
            end
         end
         S_GAP: begin
            if (cnt_r >= GAP_LAST) state_n = S_SEND;
            else                   cnt_n   = cnt_inc;
         end
         default: state_n = S_IDLE;
      endcase

      cmd_valid_n = (state_n == S_SEND);
      cmd_data_n  = cmd_valid_n ? byte_data(txn_n, byte_n) : 8'h00;
      cmd_start_n = cmd_valid_n && (byte_n == 2'd0);
      cmd_stop_n  = cmd_valid_n && (byte_n == last_of(txn_n));
      busy_n      = (state_n == S_WAIT_PWR) || (state_n == S_SEND) ||
                    (state_n == S_WAIT_RSP) || (state_n == S_GAP);
      done_n      = (state_n == S_DONE);
      error_n     = (state_n == S_ERROR);
   end

   // State and registered outputs
   always_ff @(posedge sys0_clk or posedge sys0_rst) begin
      if (sys0_rst) begin
         state_r   <= S_IDLE;
         txn_r     <= '0;
         byte_r    <= '0;
         retry_r   <= '0;
         cnt_r     <= '0;
         auto_r    <= AUTO_START;
         cmd_valid <= 1'b0;
         cmd_data  <= 8'h00;
         cmd_start <= 1'b0;
         cmd_stop  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_idx   <= '0;
      end else begin
         state_r   <= state_n;
         txn_r     <= txn_n;
         byte_r    <= byte_n;
         retry_r   <= retry_n;
         cnt_r     <= cnt_n;
         auto_r    <= 1'b0;
         cmd_valid <= cmd_valid_n;
         cmd_data  <= cmd_data_n;
         cmd_start <= cmd_start_n;
         cmd_stop  <= cmd_stop_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= error_n;
         err_idx   <= err_idx_n;
      end
   end

endmodule

// File: tb/tb_hdmi_i2c_init_seq.sv
// Bench for hdmi_i2c_init_seq: a randomized I2C-master model answers the sequencer and every
// accepted byte is scored against a transaction list built from the register table and NACK plan.
module tb_hdmi_i2c_init_seq;

   localparam int unsigned DLY  = 100;
   localparam int unsigned GAPC = 25;
   localparam int unsigned MAXR = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       rsp_valid = 1'b0;
   logic       rsp_nack = 1'b0;
   logic       cmd_valid, cmd_start, cmd_stop, busy, done, error;
   logic [7:0] cmd_data;
   logic [3:0] err_idx;

   always #5 clk = ~clk;

   hdmi_i2c_init_seq #(
      .DELAY_CYC(DLY), .MUX_ADDR(7'h74), .MUX_CHAN(8'h20), .DEV_ADDR(7'h39),
      .MAX_RETRY(MAXR), .RETRY_GAP(GAPC), .AUTO_START(1'b1)
   ) dut (
      .sys0_clk(clk), .sys0_rst(rst), .start(start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop),
      .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
      .busy(busy), .done(done), .error(error), .err_idx(err_idx)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         st;
      bit         sp;
      bit         nack;
      int         txn;
      int         b;
   } item_t;

   item_t exp_q[$];
   bit    exp_done, exp_err;
   int    exp_idx;
   int    nack_cnt[13];
   int    nack_byte[13];
   logic [7:0] reg_tab[12] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2,
                               8'hA3, 8'hE0, 8'hF9, 8'h15, 8'h16, 8'hAF};
   logic [7:0] val_tab[12] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4,
                               8'hA4, 8'hD0, 8'h00, 8'h01, 8'h38, 8'h06};

   function automatic void clear_plan();
      for (int t = 0; t < 13; t++) begin
         nack_cnt[t]  = 0;
         nack_byte[t] = 0;
      end
   endfunction

   // Expected byte stream: attempt each transaction until an attempt ACKs every byte
   function automatic void build_model();
      exp_q.delete();
      exp_done = 1'b1;
      exp_err  = 1'b0;
      exp_idx  = 0;
      for (int t = 0; t < 13; t++) begin
         int nb;
         bit ok;
         nb = (t == 0) ? 2 : 3;
         ok = 1'b0;
         for (int a = 0; a <= int'(MAXR) && !ok; a++) begin
            bit nk;
            nk = 1'b0;
            for (int b = 0; b < nb && !nk; b++) begin
               item_t it;
               if (b == 0)      it.data = (t == 0) ? {7'h74, 1'b0} : {7'h39, 1'b0};
               else if (t == 0) it.data = 8'h20;
               else             it.data = (b == 1) ? reg_tab[t-1] : val_tab[t-1];
               it.st   = (b == 0);
               it.sp   = (b == nb - 1);
               it.nack = (a < nack_cnt[t]) && (b == nack_byte[t]);
               it.txn  = t;
               it.b    = b;
               exp_q.push_back(it);
               nk = it.nack;
            end
            if (!nk) ok = 1'b1;
         end
         if (!ok) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_idx  = t;
            return;
         end
      end
   endfunction

   // Master model: one outstanding byte, random ready stalls and response latency
   task automatic run(input string tag, input int start_exp, input int stall_pct, input int start_at,
                      input bit force_stall, input int abort_txn, input bit spurious);
      int    budget, gap_cnt, gap_exp, stall, rsp_dly, accepted, total, tail, extra_valid;
      bit    measuring, presenting, outstanding, finished, aborted;
      logic [9:0] cap;
      item_t cur;
      budget = 20000; gap_cnt = 0; gap_exp = start_exp; stall = 0; rsp_dly = 0;
      accepted = 0; total = exp_q.size(); tail = -1; extra_valid = 0;
      measuring = 1'b1; presenting = 1'b0; outstanding = 1'b0; finished = 1'b0; aborted = 1'b0;
      cap = '0;
      cur = '{default: 0};
      while (budget > 0) begin
         @(negedge clk);
         budget--;
         start = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; cmd_ready = 1'b0;
         if (tail >= 0) begin
            if (cmd_valid) extra_valid++;
            if (tail == 0) begin finished = 1'b1; break; end
            tail--;
            continue;
         end
         if (measuring) begin
            if (cmd_valid) begin
               check({tag, " gap"}, gap_cnt, gap_exp);
               measuring = 1'b0;
            end else begin
               gap_cnt++;
               if (spurious && gap_cnt == 10) begin
                  rsp_valid = 1'b1;
                  rsp_nack  = 1'($urandom_range(0, 1));
                  spurious  = 1'b0;
               end
            end
         end
         if (outstanding) begin
            check({tag, " idle"}, cmd_valid, 0);
            if (abort_txn >= 0 && cur.txn == abort_txn) begin
               rst = 1'b1;
               #1;
               check({tag, " rst valid"}, cmd_valid, 0);
               check({tag, " rst busy"}, busy, 0);
               aborted  = 1'b1;
               finished = 1'b1;
               break;
            end
            if (rsp_dly > 0) rsp_dly--;
            else begin
               rsp_valid   = 1'b1;
               rsp_nack    = cur.nack;
               outstanding = 1'b0;
               if (exp_q.size() == 0) tail = 40;
               else begin
                  measuring = 1'b1;
                  gap_cnt   = 0;
                  gap_exp   = cur.nack ? int'(GAPC) : 0;
               end
            end
         end else if (cmd_valid) begin
            if (!presenting) begin
               presenting = 1'b1;
               cap = {cmd_start, cmd_stop, cmd_data};
               if (force_stall && exp_q.size() > 0 && exp_q[0].txn == 1 && exp_q[0].b == 1)
                  stall = 10;
               else
                  stall = ($urandom_range(0, 99) < stall_pct) ? int'($urandom_range(1, 4)) : 0;
            end else begin
               check({tag, " stable"}, {cmd_start, cmd_stop, cmd_data}, cap);
            end
            if (stall > 0) stall--;
            else begin
               cmd_ready  = 1'b1;
               presenting = 1'b0;
               if (exp_q.size() == 0) begin
                  check({tag, " byte count"}, accepted + 1, total);
                  finished = 1'b1;
                  break;
               end
               cur = exp_q.pop_front();
               check({tag, " byte"}, {cmd_start, cmd_stop, cmd_data}, {cur.st, cur.sp, cur.data});
               check({tag, " busy"}, busy, 1);
               accepted++;
               if (accepted == start_at) start = 1'b1;
               outstanding = 1'b1;
               rsp_dly = $urandom_range(0, 3);
            end
         end
      end
      cmd_ready = 1'b0; rsp_valid = 1'b0; start = 1'b0;
      check({tag, " finished"}, finished, 1);
      if (abort_txn >= 0) check({tag, " reset hit"}, aborted, 1);
      if (!aborted) begin
         check({tag, " accepted"}, accepted, total);
         check({tag, " extra valid"}, extra_valid, 0);
         check({tag, " done"}, done, exp_done);
         check({tag, " error"}, error, exp_err);
         check({tag, " err_idx"}, err_idx, exp_idx);
         check({tag, " busy end"}, busy, 0);
         check({tag, " valid end"}, cmd_valid, 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset outputs", {cmd_valid, cmd_start, cmd_stop, cmd_data, busy, done, error, err_idx}, 0);

      clear_plan(); build_model();
      rst = 1'b0;
      run("nominal", DLY, 0, -1, 1'b0, -1, 1'b0);

      clear_plan(); nack_cnt[3] = 1; nack_byte[3] = 0; build_model();
      start = 1'b1;
      run("nack_once", DLY, 20, 5, 1'b0, -1, 1'b1);

      for (int i = 0; i < 4; i++) begin
         clear_plan();
         for (int t = 0; t < 13; t++) begin
            if ($urandom_range(0, 4) == 0) begin
               nack_cnt[t]  = (i == 3 && $urandom_range(0, 2) == 0) ? 4 : int'($urandom_range(1, 3));
               nack_byte[t] = $urandom_range(0, (t == 0) ? 1 : 2);
            end
         end
         build_model();
         start = 1'b1;
         run("random", DLY, 30, int'($urandom_range(1, 30)), 1'b0, -1, 1'(i));
      end

      clear_plan(); nack_cnt[5] = 4; nack_byte[5] = $urandom_range(0, 2); build_model();
      start = 1'b1;
      run("persist", DLY, 20, -1, 1'b0, -1, 1'b0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart error", error, 0);
      check("restart busy", busy, 1);
      check("restart done", done, 0);
      check("restart err_idx", err_idx, 0);
      clear_plan(); build_model();
      run("rerun", DLY - 1, 0, -1, 1'b1, -1, 1'b0);

      clear_plan(); build_model();
      start = 1'b1;
      run("abort", DLY, 10, -1, 1'b0, 7, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("in reset", {cmd_valid, busy, done, error}, 0);
      rst = 1'b0;
      clear_plan(); build_model();
      run("after_rst", DLY, 0, -1, 1'b0, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
